// File: rtl/pipe_datapath.sv
// pipe_datapath: three-stage (ID/EX/WB) pipelined datapath with its own
// register bank and ALU, EX/WB forwarding and a load-use interlock.
// Optional macro DP_FWD_EN: defined = bypass paths + one-cycle load-use
// stall; undefined = no bypass, issue waits until in-flight writers retire.
// Ports: clk, reset (sync, active-high); issue side in_valid/in_ready,
// rs/rt/rd_addr, wr_reg, m_to_reg, alu_control, alu_src, imm_ext;
// memory side mem_data_in (load data), alu_result_out (address);
// WB view wb_valid, wb_we, wb_addr, writeback_data, zero/negative/overflow.
module pipe_datapath #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4,
   parameter int ZERO_REG   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  wr_reg,
   input  logic                  m_to_reg,
   input  logic [3:0]            alu_control,
   input  logic                  alu_src,
   input  logic [DATA_W-1:0]     imm_ext,
   input  logic [DATA_W-1:0]     mem_data_in,
   output logic [DATA_W-1:0]     alu_result_out,
   output logic                  wb_valid,
   output logic                  wb_we,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]     writeback_data,
   output logic                  zero_flag,
   output logic                  negative_flag,
   output logic                  overflow_flag
);

   localparam int NREG = 2**REG_ADDR_W;
   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;
   localparam bit ZR   = (ZERO_REG != 0);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_PASS = 4'd11;

   logic [DATA_W-1:0] rf [NREG];

   logic                  ex_valid;
   logic                  ex_wr;
   logic                  ex_m2r;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [3:0]            ex_op;
   logic [DATA_W-1:0]     ex_a;
   logic [DATA_W-1:0]     ex_b;

   logic wb_wr;
   logic wb_m2r;

   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf;
   logic [SH_W-1:0]   shamt;

   logic [DATA_W-1:0] rf_rs, rf_rt;
   logic [DATA_W-1:0] rs_val, rt_val;
   logic              ex_dst_ok;
   logic              rs_ex_hit, rt_ex_hit;
   logic              rs_wb_hit, rt_wb_hit;
   logic              stall;
   logic              accept;

   // WB stage
   assign writeback_data = wb_m2r ? mem_data_in : alu_result_out;
   assign wb_we = wb_valid && wb_wr && !(ZR && wb_addr == '0);

   // ID stage: hazard detection against EX and WB destinations
   assign ex_dst_ok = ex_valid && ex_wr && !(ZR && ex_rd == '0);
   assign rs_ex_hit = ex_dst_ok && (ex_rd == rs_addr);
   assign rt_ex_hit = alu_src && ex_dst_ok && (ex_rd == rt_addr);
   assign rs_wb_hit = wb_we && (wb_addr == rs_addr);
   assign rt_wb_hit = alu_src && wb_we && (wb_addr == rt_addr);

   assign rf_rs = (ZR && rs_addr == '0) ? '0 : rf[rs_addr];
   assign rf_rt = (ZR && rt_addr == '0) ? '0 : rf[rt_addr];

   always_comb begin
      rs_val = rf_rs;
      rt_val = rf_rt;
      stall  = 1'b0;
`ifdef DP_FWD_EN
      // EX has priority; a load in EX cannot forward and stalls instead
      if (rs_ex_hit && !ex_m2r)
         rs_val = alu_res;
      else if (rs_wb_hit)
         rs_val = writeback_data;
      if (rt_ex_hit && !ex_m2r)
         rt_val = alu_res;
      else if (rt_wb_hit)
         rt_val = writeback_data;
      stall = ex_m2r && (rs_ex_hit || rt_ex_hit);
`else
      stall = rs_ex_hit || rt_ex_hit
           || rs_wb_hit || rt_wb_hit;
`endif
   end

   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   // EX stage ALU
   assign shamt = ex_b[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (ex_op)
         OP_ADD: begin
            alu_res = ex_a + ex_b;
            alu_ovf = (ex_a[MSB] == ex_b[MSB])
                   && (alu_res[MSB] != ex_a[MSB]);
         end
         OP_SUB: begin
            alu_res = ex_a - ex_b;
            alu_ovf = (ex_a[MSB] != ex_b[MSB])
                   && (alu_res[MSB] != ex_a[MSB]);
         end
         OP_AND:  alu_res = ex_a & ex_b;
         OP_OR:   alu_res = ex_a | ex_b;
         OP_XOR:  alu_res = ex_a ^ ex_b;
         OP_NOR:  alu_res = ~(ex_a | ex_b);
         OP_SLL:  alu_res = ex_a << shamt;
         OP_SRL:  alu_res = ex_a >> shamt;
         OP_SRA:  alu_res = $signed(ex_a) >>> shamt;
         OP_SLT:  alu_res = {{MSB{1'b0}},
                             $signed(ex_a) < $signed(ex_b)};
         OP_SLTU: alu_res = {{MSB{1'b0}}, ex_a < ex_b};
         OP_PASS: alu_res = ex_b;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid       <= 1'b0;
         ex_wr          <= 1'b0;
         ex_m2r         <= 1'b0;
         ex_rd          <= '0;
         ex_op          <= '0;
         ex_a           <= '0;
         ex_b           <= '0;
         wb_valid       <= 1'b0;
         wb_wr          <= 1'b0;
         wb_m2r         <= 1'b0;
         wb_addr        <= '0;
         alu_result_out <= '0;
         zero_flag      <= 1'b0;
         negative_flag  <= 1'b0;
         overflow_flag  <= 1'b0;
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else begin
         ex_valid <= accept;
         if (accept) begin
            ex_wr  <= wr_reg;
            ex_m2r <= m_to_reg;
            ex_rd  <= rd_addr;
            ex_op  <= alu_control;
            ex_a   <= rs_val;
            ex_b   <= alu_src ? rt_val : imm_ext;
         end
         wb_valid       <= ex_valid;
         wb_wr          <= ex_wr;
         wb_m2r         <= ex_m2r;
         wb_addr        <= ex_rd;
         alu_result_out <= alu_res;
         zero_flag      <= (alu_res == '0);
         negative_flag  <= alu_res[MSB];
         overflow_flag  <= alu_ovf;
         if (wb_we)
            rf[wb_addr] <= writeback_data;
      end
   end

endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: directed scenarios plus random issue stream checked
// against a sequential-semantics reference model and a WB scoreboard.
`timescale 1ns/1ps
module tb_pipe_datapath;

   localparam bit          ZR    = 1'b1;
   localparam logic [31:0] MEM_K = 32'h5A5A_A5A5;
`ifdef DP_FWD_EN
   localparam bit          FWD   = 1'b1;
`else
   localparam bit          FWD   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  rs_addr, rt_addr, rd_addr;
   logic        wr_reg, m_to_reg;
   logic [3:0]  alu_control;
   logic        alu_src;
   logic [31:0] imm_ext;
   logic [31:0] mem_data_in;
   logic [31:0] alu_result_out;
   logic        wb_valid, wb_we;
   logic [3:0]  wb_addr;
   logic [31:0] writeback_data;
   logic        zero_flag, negative_flag, overflow_flag;

   int total = 0;
   int bad   = 0;
   bit sb_en = 1'b0;

   always #5 clk = ~clk;

   // data memory: load data is a fixed function of the address
   assign mem_data_in = alu_result_out ^ MEM_K;

   pipe_datapath #(
      .DATA_W(32), .REG_ADDR_W(4), .ZERO_REG(1)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .wr_reg(wr_reg), .m_to_reg(m_to_reg),
      .alu_control(alu_control), .alu_src(alu_src),
      .imm_ext(imm_ext), .mem_data_in(mem_data_in),
      .alu_result_out(alu_result_out),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
      .writeback_data(writeback_data),
      .zero_flag(zero_flag), .negative_flag(negative_flag),
      .overflow_flag(overflow_flag)
   );

   typedef struct {
      bit          v;
      bit          wr;
      bit          m2r;
      logic [3:0]  rd;
      logic [31:0] res;
      logic [31:0] wbd;
      logic [2:0]  f;
   } slot_t;

   slot_t       m_ex, m_wb;
   logic [31:0] ref_rf [16];

   function automatic logic [31:0] ref_alu(input logic [3:0] op,
         input logic [31:0] a, input logic [31:0] b, output bit ov);
      longint sa, sb, s;
      int     sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      ov = 1'b0;
      case (op)
         4'd0: begin
            s  = sa + sb;
            ov = (s != longint'($signed(s[31:0])));
            return s[31:0];
         end
         4'd1: begin
            s  = sa - sb;
            ov = (s != longint'($signed(s[31:0])));
            return s[31:0];
         end
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return a << sh;
         4'd7:  return a >> sh;
         4'd8:  return $signed(a) >>> sh;
         4'd9:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd10: return (a < b) ? 32'd1 : 32'd0;
         4'd11: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit writes(input slot_t s, input logic [3:0] a);
      return s.v && s.wr && !(ZR && s.rd == 4'd0) && s.rd == a;
   endfunction

   function automatic logic [31:0] rd_ref(input logic [3:0] a);
      return (ZR && a == 4'd0) ? 32'd0 : ref_rf[a];
   endfunction

   // scoreboard: model holds the instruction expected in EX and in WB
   always @(negedge clk) begin : scoreboard
      slot_t       nw;
      bit          stall_e;
      bit          we_e;
      bit          ov;
      logic [31:0] a, b;
      if (sb_en) begin
         total++;
         we_e = m_wb.v && m_wb.wr && !(ZR && m_wb.rd == 4'd0);
         if (m_wb.v) begin
            if (wb_valid !== 1'b1 || wb_we !== we_e
                || wb_addr !== m_wb.rd
                || alu_result_out !== m_wb.res
                || writeback_data !== m_wb.wbd
                || {zero_flag, negative_flag, overflow_flag} !== m_wb.f)
            begin
               bad++;
               $display("FAIL wb_stage t=%0t: got v=%b we=%b a=%0d r=%h d=%h f=%b%b%b, expected v=1 we=%b a=%0d r=%h d=%h f=%b",
                  $time, wb_valid, wb_we, wb_addr, alu_result_out,
                  writeback_data, zero_flag, negative_flag,
                  overflow_flag, we_e, m_wb.rd, m_wb.res, m_wb.wbd,
                  m_wb.f);
            end
         end else if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            bad++;
            $display("FAIL wb_bubble t=%0t: got v=%b we=%b, expected 0 0",
               $time, wb_valid, wb_we);
         end
         if (FWD)
            stall_e = m_ex.v && m_ex.m2r
                   && (writes(m_ex, rs_addr)
                       || (alu_src && writes(m_ex, rt_addr)));
         else
            stall_e = writes(m_ex, rs_addr) || writes(m_wb, rs_addr)
                   || (alu_src && (writes(m_ex, rt_addr)
                                   || writes(m_wb, rt_addr)));
         total++;
         if (in_ready !== !stall_e) begin
            bad++;
            $display("FAIL in_ready t=%0t: got %b, expected %b",
               $time, in_ready, !stall_e);
         end
      end
      nw.v   = 1'b0;
      nw.wr  = 1'b0;
      nw.m2r = 1'b0;
      nw.rd  = 4'd0;
      nw.res = 32'd0;
      nw.wbd = 32'd0;
      nw.f   = 3'd0;
      if (in_valid && in_ready && !reset) begin
         a      = rd_ref(rs_addr);
         b      = alu_src ? rd_ref(rt_addr) : imm_ext;
         nw.v   = 1'b1;
         nw.wr  = wr_reg;
         nw.m2r = m_to_reg;
         nw.rd  = rd_addr;
         nw.res = ref_alu(alu_control, a, b, ov);
         nw.wbd = m_to_reg ? (nw.res ^ MEM_K) : nw.res;
         nw.f   = {nw.res == 32'd0, nw.res[31], ov};
         if (wr_reg && !(ZR && rd_addr == 4'd0))
            ref_rf[rd_addr] = nw.wbd;
      end
      if (reset) begin
         m_ex.v = 1'b0;
         m_wb.v = 1'b0;
         for (int i = 0; i < 16; i++)
            ref_rf[i] = 32'd0;
      end else begin
         m_wb = m_ex;
         m_ex = nw;
      end
   end

   task automatic issue(input logic [3:0] rs, input logic [3:0] rt,
         input logic [3:0] rd, input logic wr, input logic m2r,
         input logic [3:0] op, input logic src,
         input logic [31:0] imm, output int stalls);
      bit done = 1'b0;
      rs_addr     = rs;
      rt_addr     = rt;
      rd_addr     = rd;
      wr_reg      = wr;
      m_to_reg    = m2r;
      alu_control = op;
      alu_src     = src;
      imm_ext     = imm;
      in_valid    = 1'b1;
      stalls      = 0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         done = (in_ready === 1'b1);
         if (!done)
            stalls++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: stalled %0d cycles, required accept",
            stalls);
      end
   endtask

   // issue, then sample the instruction in its WB cycle
   task automatic exec(input logic [3:0] rs, input logic [3:0] rt,
         input logic [3:0] rd, input logic wr, input logic [3:0] op,
         input logic src, input logic [31:0] imm,
         output logic [31:0] d, output logic [2:0] f);
      int s;
      issue(rs, rt, rd, wr, 1'b0, op, src, imm, s);
      @(posedge clk);
      @(negedge clk);
      d = writeback_data;
      f = {zero_flag, negative_flag, overflow_flag};
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
      logic [2:0] f;
      exec(a, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0, v, f);
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      in_valid    = 1'b0;
      rs_addr     = 4'd0;
      rt_addr     = 4'd0;
      rd_addr     = 4'd0;
      wr_reg      = 1'b0;
      m_to_reg    = 1'b0;
      alu_control = 4'd0;
      alu_src     = 1'b0;
      imm_ext     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb_en = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b, expected 1", in_ready);
      end
      total++;
      if ({wb_valid, wb_we, wb_addr} !== 6'd0) begin
         bad++;
         $display("FAIL reset_wb: got v=%b we=%b a=%0d, expected 0",
            wb_valid, wb_we, wb_addr);
      end
      total++;
      if (alu_result_out !== 32'd0 || writeback_data !== 32'd0
          || {zero_flag, negative_flag, overflow_flag} !== 3'd0) begin
         bad++;
         $display("FAIL reset_data: got r=%h d=%h f=%b%b%b, expected 0",
            alu_result_out, writeback_data, zero_flag,
            negative_flag, overflow_flag);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int          s;
      logic [31:0] v;
      issue(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd5, s);
      issue(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 32'd7, s);
      @(negedge clk);
      total++;
      if (writeback_data !== 32'd5) begin
         bad++;
         $display("FAIL basic_wb1: got %h, expected 5", writeback_data);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (writeback_data !== 32'd7) begin
         bad++;
         $display("FAIL basic_wb2: got %h, expected 7", writeback_data);
      end
      @(posedge clk);
      #1;
      read_reg(4'd1, v);
      total++;
      if (v !== 32'd5) begin
         bad++;
         $display("FAIL basic_r1: got %h, expected 5", v);
      end
      read_reg(4'd2, v);
      total++;
      if (v !== 32'd7) begin
         bad++;
         $display("FAIL basic_r2: got %h, expected 7", v);
      end
   endtask

   task automatic test_dependency();
      int          s1, s2;
      logic [31:0] v;
      issue(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1, 32'd0, s1);
      issue(4'd3, 4'd1, 4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 32'd0, s2);
      total++;
      if (s2 !== (FWD ? 0 : 2)) begin
         bad++;
         $display("FAIL dep_stalls: got %0d, expected %0d",
            s2, FWD ? 0 : 2);
      end
      read_reg(4'd4, v);
      total++;
      if (v !== 32'd7) begin
         bad++;
         $display("FAIL dep_r4: got %h, expected 7", v);
      end
      // WB-stage producer meets the ID-stage reader in the same cycle
      issue(4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 32'h123, s1);
      @(posedge clk);
      #1;
      issue(4'd9, 4'd0, 4'd10, 1'b1, 1'b0, 4'd0, 1'b0, 32'd1, s2);
      total++;
      if (s2 !== (FWD ? 0 : 1)) begin
         bad++;
         $display("FAIL wbfwd_stalls: got %0d, expected %0d",
            s2, FWD ? 0 : 1);
      end
      read_reg(4'd10, v);
      total++;
      if (v !== 32'h124) begin
         bad++;
         $display("FAIL wbfwd_r10: got %h, expected 124", v);
      end
   endtask

   task automatic test_load_use();
      int          s1, s2;
      logic [31:0] v;
      issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0,
            32'hDEADBEEF ^ MEM_K, s1);
      issue(4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 4'd0, 1'b1, 32'd0, s2);
      total++;
      if (s2 !== (FWD ? 1 : 2)) begin
         bad++;
         $display("FAIL lu_stalls: got %0d, expected %0d",
            s2, FWD ? 1 : 2);
      end
      read_reg(4'd6, v);
      total++;
      if (v !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL lu_r6: got %h, expected deadbeef", v);
      end
      // rt names the load target but is unused with alu_src=0
      issue(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 32'h100, s1);
      issue(4'd0, 4'd7, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0, 32'd3, s2);
      total++;
      if (s2 !== 0) begin
         bad++;
         $display("FAIL lu_rt_unused: got %0d stalls, expected 0", s2);
      end
      read_reg(4'd8, v);
      total++;
      if (v !== 32'd3) begin
         bad++;
         $display("FAIL lu_r8: got %h, expected 3", v);
      end
   endtask

   task automatic test_flags();
      int          s;
      logic [31:0] d;
      logic [2:0]  f;
      issue(4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0, 32'h7FFFFFFF, s);
      exec(4'd8, 4'd0, 4'd9, 1'b1, 4'd0, 1'b0, 32'd1, d, f);
      total++;
      if (d !== 32'h80000000 || f !== 3'b011) begin
         bad++;
         $display("FAIL flag_ovf: got d=%h zno=%b, expected 80000000 011",
            d, f);
      end
      issue(4'd0, 4'd0, 4'd10, 1'b1, 1'b0, 4'd0, 1'b0, 32'd9, s);
      exec(4'd10, 4'd0, 4'd11, 1'b1, 4'd1, 1'b0, 32'd9, d, f);
      total++;
      if (d !== 32'd0 || f !== 3'b100) begin
         bad++;
         $display("FAIL flag_zero: got d=%h zno=%b, expected 0 100", d, f);
      end
      exec(4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 32'h55, d, f);
      read_reg(4'd0, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL zero_reg: got %h, expected 0", d);
      end
   endtask

   task automatic test_reset_midflight();
      int          s;
      logic [31:0] v;
      issue(4'd0, 4'd0, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, 32'h11, s);
      issue(4'd0, 4'd0, 4'd13, 1'b1, 1'b0, 4'd0, 1'b0, 32'h22, s);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({wb_valid, wb_we, wb_addr} !== 6'd0 || alu_result_out !== 32'd0
          || writeback_data !== 32'd0 || in_ready !== 1'b1
          || {zero_flag, negative_flag, overflow_flag} !== 3'd0) begin
         bad++;
         $display("FAIL midreset_out: got v=%b we=%b a=%0d r=%h d=%h rdy=%b, expected 0s rdy=1",
            wb_valid, wb_we, wb_addr, alu_result_out, writeback_data,
            in_ready);
      end
      @(posedge clk);
      #1;
      read_reg(4'd12, v);
      total++;
      if (v !== 32'd0) begin
         bad++;
         $display("FAIL midreset_r12: got %h, expected 0", v);
      end
      read_reg(4'd13, v);
      total++;
      if (v !== 32'd0) begin
         bad++;
         $display("FAIL midreset_r13: got %h, expected 0", v);
      end
      read_reg(4'd1, v);
      total++;
      if (v !== 32'd0) begin
         bad++;
         $display("FAIL midreset_r1: got %h, expected 0", v);
      end
   endtask

   task automatic test_random();
      int          s;
      logic [31:0] imm;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = $urandom_range(0, 40);
            2: imm = 32'h7FFFFFFF;
            default: imm = 32'h80000000;
         endcase
         issue(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), $urandom_range(0, 5) != 0,
               $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), imm, s);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_dependency();
      test_load_use();
      test_flags();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
- Parametrised three-stage pipelined successor to the single-cycle datapath.
- Stages: ID (register read, operand select), EX (ALU), WB (load/ALU writeback mux, register write).
- Contains its own register bank and ALU, with EX/WB forwarding and a load-use interlock.
- Sits between the control FSM/decoder (issue side) and the asynchronous-read data memory.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_ADDR_W, 4, register address width; register count is 2**REG_ADDR_W.
- ZERO_REG, 0, when 1 register 0 reads as zero and writes to it are discarded.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  issue request.
- in_ready  output  1  issue accepted when in_valid && in_ready.
- rs_addr  input  REG_ADDR_W  source A.
- rt_addr  input  REG_ADDR_W  source B.
- rd_addr  input  REG_ADDR_W  destination.
- wr_reg  input  1  instruction writes rd.
- m_to_reg  input  1  1 = load (write mem_data_in), 0 = write ALU result.
- alu_control  input  4  ALU op.
- alu_src  input  1  1 = operand B is rt, 0 = imm_ext.
- imm_ext  input  DATA_W  sign-extended immediate.
- mem_data_in  input  DATA_W  load data, valid combinationally in the WB cycle.
- alu_result_out  output  DATA_W  registered EX result in WB stage (memory address).
- wb_valid  output  1  WB stage holds an instruction.
- wb_we  output  1  register write occurs at the end of this cycle.
- wb_addr  output  REG_ADDR_W  WB destination.
- writeback_data  output  DATA_W  m_to_reg ? mem_data_in : alu_result_out (WB stage).
- zero_flag  output  1  registered with alu_result_out.
- negative_flag  output  1  registered with alu_result_out.
- overflow_flag  output  1  registered with alu_result_out.

Behaviour:
- Reset (synchronous, active-high): all registers and stage valids 0, all outputs 0, in_ready 1 the next cycle. In-flight instructions are discarded and never written back.
- Pipeline timing: issue accepted in cycle N → EX in N+1 → WB in N+2. Register written at the edge ending N+2. Pipeline never stalls downstream; bubbles carry valid=0.
- wb_we = wb_valid && wr_reg && !(ZERO_REG && wb_addr==0).
- ALU ops (B = selected operand, shift amount B[log2(DATA_W)-1:0]): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT signed, 10 SLTU, 11 PASSB; 12-15 give 0.
- Flags: overflow is signed overflow for ADD/SUB only, else 0. zero = (result==0). negative = result MSB.
- Source usage: rs is always used; rt is used only when alu_src=1.
- Forwarding, per used source with a matching destination (wr_reg=1, valid, and not register 0 when ZERO_REG):
  - EX match has priority over WB match.
  - EX non-load match → forward the combinational ALU result.
  - WB match → forward writeback_data.
  - Otherwise read the register bank.
- Load-use: EX holds a load (m_to_reg=1) whose rd matches a used source → in_ready=0 for one cycle and a bubble enters EX.
- Same-cycle WB write and ID read of one register returns the new value via forwarding.
- in_valid=0 inserts a bubble.

Optional Feature:
- Macro DP_FWD_EN.
- Defined: forwarding and single-cycle load-use stall as above.
- Undefined: no bypass paths. in_ready=0 while any valid EX or WB instruction writes a used source register. Dependent back-to-back ops therefore wait 2 extra cycles; the register bank supplies all operands.

Test Plan:
- Reset, then issue ADD r1=r0+imm 5 and ADD r2=r0+imm 7 → wb_data 5 then 7; r1=5, r2=7 after 4 cycles.
- DP_FWD_EN defined: ADD r3=r1+r2 followed immediately by SUB r4=r3-r1 → no stall, r4=7.
- Load-use: load r5 (mem_data_in=0xDEADBEEF) then ADD r6=r5+r0 → in_ready low exactly 1 cycle, r6=0xDEADBEEF.
- Flags: ADD 0x7FFFFFFF+1 → overflow=1, negative=1, zero=0. SUB 9-9 → zero=1.
- Reset asserted while two instructions are in EX/WB → no register changes, all outputs 0 the next cycle.
- DP_FWD_EN undefined: the dependent pair from the forwarding scenario → in_ready low 2 cycles, same final r4=7.
